m31_mul_accumulator: RTL and testbench
======================================

Name: m31_mul_accumulator

Overview:
- Downstream consumer of the pipelined M31 multiplier. Accepts a stream of reduced products and accumulates them mod p = 2^31-1.
- When the beat marked last arrives, emits the canonical sum. This is the dot-product and row-sum stage of the Monolith MDS/linear layer.
- Uses a valid/ready handshake on both sides and holds its result under back-pressure.

Parameters:
- DATA_WIDTH, 31, element width; fixed to the M31 field, other values unsupported.
- MAX_TERMS, 24, maximum beats per accumulation (Monolith-31 state width). Sets the counter width to clog2(MAX_TERMS+1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- in_data  in  DATA_WIDTH  product from the multiplier; value in [0, p]. Both 0 and p mean zero.
- in_valid  in  1  in_data/in_last valid.
- in_last  in  1  final term of the current accumulation.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  DATA_WIDTH  accumulated sum, canonical [0, p-1].
- out_count  out  clog2(MAX_TERMS+1)  number of terms in out_data.
- out_err  out  1  term-limit violation flag (see Optional Feature).
- out_valid  out  1  out_data/out_count/out_err valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (reset=0 at posedge) forces: state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, out_count=0, out_err=0, in_ready=0 during the reset cycle.
- Reset mid-accumulation or mid-HOLD discards all partial or held results. No output beat is produced.
- Beat accepted = in_valid & in_ready on a posedge.
- in_valid may rise without waiting for in_ready, but in_data and in_last must stay stable until accepted.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accepted non-last beat: acc <= madd(acc, in_data); cnt <= cnt+1.
  - Accepted last beat: out_data <= madd(acc, in_data); out_count <= cnt+1; acc <= 0; cnt <= 0; go to HOLD.
  - No accepted beat: hold state.
- State HOLD:
  - out_valid=1, in_ready=0.
  - On out_valid & out_ready: go to ACCUM, out_valid <= 0.
  - Outputs stay stable until accepted.
- Latency: out_valid asserts the cycle after the last beat is accepted.
- Throughput: a result of N terms occupies N+1 cycles with out_ready held at 1. Minimum 2 cycles per single-term result.
- madd(a,b), combinational:
  - b' = (b==p) ? 0 : b.
  - s = a + b' as 32 bits.
  - Result is s - p if s >= p, else s.
  - Output is always in [0, p-1]. acc is canonical at all times.
- Single-beat accumulation (first beat has in_last=1) is legal; out_count=1.
- in_last on an idle bus (in_valid=0) is ignored.
- cnt never wraps; the overflow case is handled as below.

Optional Feature:
- Macro: M31_ACC_TERM_LIMIT_EN.
- Defined:
  - If a non-last beat is accepted when cnt == MAX_TERMS-1, that beat is treated as last.
  - The result is emitted with out_count=MAX_TERMS and out_err=1.
  - out_err clears when the result is accepted. Remaining input beats start a new accumulation.
- Undefined:
  - No limit check; out_err is tied to 0.
  - Supplying more than MAX_TERMS beats without in_last is illegal and out_count is unspecified.
  - Sum correctness is preserved regardless.

Decomposition:
- Shared package m31_pkg holds:
  - M31_P = 31'h7FFF_FFFF.
  - typedef m31_t (logic [30:0]).
  - Enum acc_state_t {ACCUM, HOLD}.
  - Function clog2 width helper, if not already present.
- One natural sub-module: m31_mod_add, the combinational madd above. It is reusable by the MDS and round-constant stages.

Test Plan:
- Sum 3+5+7 with last on 7, out_ready=1 → one cycle after the last beat: out_data=15, out_count=3, out_valid for 1 cycle.
- Wrap-around: 0x7FFFFFFE + 0x00000005 (last) → out_data=0x00000004. Also 0x7FFFFFFE + 0x00000001 → 0x00000000.
- Non-canonical zero: inputs 0x7FFFFFFF, 0x7FFFFFFF, 9 (last) → out_data=9, out_count=3.
- Back-pressure: out_ready=0 for 5 cycles after result 42 → out_data/out_valid stable and in_ready=0 throughout. When out_ready=1, the next stream (1, 1 last) gives 2 with acc fresh.
- Reset mid-stream: accept 100, 200, then reset=0 one cycle, then 7 (last) → out_data=7, out_count=1, no earlier output.
- With M31_ACC_TERM_LIMIT_EN, MAX_TERMS=4: stream 1,1,1,1,1 (last on 5th) → first result out_data=4, out_count=4, out_err=1. Second result out_data=1, out_count=1, out_err=0.

Source files
------------

// File: rtl/m31_pkg.sv
// m31_pkg: shared definitions for the Mersenne-31 (p = 2^31-1) datapath.
//   M31_W        element width
//   M31_P        the field modulus
//   m31_t        one field element (31 bits)
//   acc_state_t  accumulator control states
//   m31_clog2    constant-function width helper (ceil(log2(value)), minimum 1)
package m31_pkg;

  localparam int M31_W = 31;
  localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

  typedef logic [30:0] m31_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  function automatic int m31_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

endpackage : m31_pkg

// File: rtl/m31_mod_add.sv
// m31_mod_add: combinational modular addition in GF(2^31-1).
//   a  in  m31_t  canonical operand, [0, p-1]
//   b  in  m31_t  operand in [0, p]; p is treated as the non-canonical zero
//   y  out m31_t  (a + b) mod p, always canonical [0, p-1]
module m31_mod_add
  import m31_pkg::*;
(
  input  m31_t a,
  input  m31_t b,
  output m31_t y
);

  m31_t        b_canon;
  logic [31:0] sum;
  logic [31:0] sum_minus_p;

  // Fold the non-canonical zero so the single conditional subtract below
  // is enough: with both operands <= p-1 the sum is at most 2p-2.
  assign b_canon     = (b == M31_P) ? '0 : b;
  assign sum         = {1'b0, a} + {1'b0, b_canon};
  assign sum_minus_p = sum - {1'b0, M31_P};
  assign y           = (sum >= {1'b0, M31_P}) ? sum_minus_p[30:0] : sum[30:0];

endmodule : m31_mod_add

// File: rtl/m31_mul_accumulator.sv
// m31_mul_accumulator: accumulates a stream of M31 products mod p = 2^31-1 and
// emits the canonical sum when the beat marked last is accepted. The result is
// held under back-pressure; no new beats are taken until it is consumed.
//
// Ports:
//   clk        in   single clock, posedge
//   reset      in   synchronous, active-low (0 = reset)
//   in_data    in   product, value in [0, p] (0 and p both mean zero)
//   in_valid   in   in_data/in_last valid
//   in_last    in   final term of the current accumulation
//   in_ready   out  beat can be accepted this cycle
//   out_data   out  canonical sum [0, p-1]
//   out_count  out  number of terms folded into out_data
//   out_err    out  term-limit violation flag
//   out_valid  out  out_data/out_count/out_err valid
//   out_ready  in   consumer accepts the result
//
// Build option: define M31_ACC_TERM_LIMIT_EN to force termination of a stream
// at MAX_TERMS beats (flagged with out_err). Without it out_err is always 0.
module m31_mul_accumulator
  import m31_pkg::*;
#(
  parameter  int DATA_WIDTH = 31,
  parameter  int MAX_TERMS  = 24,
  localparam int CNT_W      = m31_clog2(MAX_TERMS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  acc_state_t            state_reg;
  acc_state_t            state_next;
  m31_t                  acc_reg;
  m31_t                  acc_sum;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [CNT_W-1:0]      out_count_reg;
  logic                  out_err_reg;
  logic                  beat;
  logic                  limit_hit;
  logic                  term_last;

  m31_mod_add u_mod_add (
    .a (acc_reg),
    .b (in_data),
    .y (acc_sum)
  );

  assign beat = in_valid & in_ready;

  // Saturate so an over-long stream can never wrap the counter.
  assign cnt_inc = (cnt_reg == CNT_W'(MAX_TERMS)) ? cnt_reg : cnt_reg + CNT_W'(1);

`ifdef M31_ACC_TERM_LIMIT_EN
  // A non-last beat arriving as term MAX_TERMS closes the accumulation.
  assign limit_hit = (cnt_reg == CNT_W'(MAX_TERMS - 1)) & ~in_last;
`else
  assign limit_hit = 1'b0;
`endif

  assign term_last = in_last | limit_hit;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ACCUM;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM: if (beat && term_last) state_next = HOLD;
      HOLD:  if (out_ready)         state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Output logic; in_ready is also gated by reset so nothing looks
  // acceptable during the reset cycle.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      ACCUM: in_ready  = reset;
      HOLD:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Accumulator and result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (beat) begin
            if (term_last) begin
              out_data_reg  <= acc_sum;
              out_count_reg <= cnt_inc;
              out_err_reg   <= limit_hit;
              acc_reg       <= '0;
              cnt_reg       <= '0;
            end else begin
              acc_reg <= acc_sum;
              cnt_reg <= cnt_inc;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_err_reg <= 1'b0;
          end
        end
        default: begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign out_err   = out_err_reg;

endmodule : m31_mul_accumulator

// File: tb/tb_m31_mul_accumulator.sv
// Self-checking bench for m31_mul_accumulator. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Expected results come from a
// plain-arithmetic model of the modular sum (mod 2^31-1) over each stream.
module tb_m31_mul_accumulator;

  localparam logic [30:0] P = 31'h7FFF_FFFF;
`ifdef M31_ACC_TERM_LIMIT_EN
  localparam bit LIM = 1'b1;
  localparam int MT  = 4;
`else
  localparam bit LIM = 1'b0;
  localparam int MT  = 24;
`endif
  localparam int CW = $clog2(MT + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [30:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [30:0]   out_data;
  logic [CW-1:0] out_count;
  logic          out_err;
  logic          out_valid;
  logic          out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  longint m_sum = 0;
  int     m_cnt = 0;
  longint exp_data[$];
  int     exp_cnt[$];
  bit     exp_err[$];

  always #5 clk = ~clk;

  m31_mul_accumulator #(
    .DATA_WIDTH (31),
    .MAX_TERMS  (MT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
  endtask

  // Fold one accepted beat into the model; report whether it closes a result.
  task automatic model_beat(input logic [30:0] d, input bit last, output bit produced);
    longint dv;
    dv = longint'(d) % longint'(P);
    m_sum = (m_sum + dv) % longint'(P);
    m_cnt++;
    produced = 1'b0;
    if (last || (LIM && m_cnt == MT)) begin
      exp_data.push_back(m_sum);
      exp_cnt.push_back(m_cnt);
      exp_err.push_back(!last);
      produced = 1'b1;
      model_reset();
    end
  endtask

  // Called on the falling edge right after the closing beat was accepted.
  task automatic get_result(input int hold);
    longint ed;
    int     ec;
    bit     ee;
    ed = exp_data.pop_front();
    ec = exp_cnt.pop_front();
    ee = exp_err.pop_front();
    check("out_valid_latency", 64'(out_valid), 64'(1));
    check("out_data", 64'(out_data), 64'(ed));
    check("out_count", 64'(out_count), 64'(ec));
    check("out_err", 64'(out_err), 64'(ee));
    check("in_ready_in_hold", 64'(in_ready), 64'(0));
    $display("result data=0x%08h count=%0d err=%0d hold=%0d", out_data, out_count, out_err, hold);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(ed));
        check("hold_count", 64'(out_count), 64'(ec));
        check("hold_in_ready", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("after_accept_valid", 64'(out_valid), 64'(0));
    check("after_accept_err", 64'(out_err), 64'(0));
    check("after_accept_in_ready", 64'(in_ready), 64'(1));
  endtask

  // Present one beat, wait (bounded) for acceptance, then drain any result.
  task automatic send_beat(input logic [30:0] d, input bit last, input int hold);
    int n;
    bit produced;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 64'(n < 20), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    model_beat(d, last, produced);
    if (produced) begin
      get_result(hold);
    end else begin
      check("no_early_valid", 64'(out_valid), 64'(0));
    end
  endtask

  function automatic logic [30:0] rand_elem();
    logic [30:0] v;
    case ($urandom_range(0, 7))
      0:       v = P;
      1:       v = P - 31'd1;
      2:       v = '0;
      default: v = 31'($urandom_range(0, 32'h7FFF_FFFF));
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int maxlen;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    check("rst_out_err", 64'(out_err), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));

    // in_last on an idle bus is ignored
    in_last = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_last_valid", 64'(out_valid), 64'(0));
    in_last = 1'b0;

    // 3 + 5 + 7
    send_beat(31'd3, 1'b0, 0);
    send_beat(31'd5, 1'b0, 0);
    send_beat(31'd7, 1'b1, 0);

    // Wrap-around
    send_beat(31'h7FFF_FFFE, 1'b0, 0);
    send_beat(31'd5, 1'b1, 0);
    send_beat(31'h7FFF_FFFE, 1'b0, 0);
    send_beat(31'd1, 1'b1, 0);

    // Non-canonical zero
    send_beat(P, 1'b0, 0);
    send_beat(P, 1'b0, 0);
    send_beat(31'd9, 1'b1, 0);

    // Back-pressure on 42, then a fresh 1 + 1
    send_beat(31'd40, 1'b0, 0);
    send_beat(31'd2, 1'b1, 5);
    send_beat(31'd1, 1'b0, 0);
    send_beat(31'd1, 1'b1, 0);

    // Reset mid-stream discards the partial sum
    send_beat(31'd100, 1'b0, 0);
    send_beat(31'd200, 1'b0, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'(0));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    reset = 1'b1;
    model_reset();
    send_beat(31'd7, 1'b1, 0);

    // Full-length stream (forced split when the term limit is enabled)
    if (LIM) begin
      for (int i = 0; i < 5; i++) send_beat(31'd1, i == 4, 0);
    end else begin
      for (int i = 0; i < MT; i++) send_beat(P - 31'd1, i == MT - 1, 0);
    end

    // Randomized streams with idle gaps and random back-pressure
    maxlen = LIM ? MT + 3 : MT;
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, maxlen);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          @(negedge clk);
          check("gap_valid", 64'(out_valid), 64'(0));
          in_last = 1'b0;
        end
        send_beat(rand_elem(), b == len - 1, $urandom_range(0, 3));
      end
    end

    check("queue_drained", 64'(exp_data.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_m31_mul_accumulator
